// File: rtl/decrypt128_if.sv
// -----------------------------------------------------------------------------
// decrypt128_if
// Bundles the data-facing signals of the decrypt128 AES-128 inverse cipher.
//
// Signals:
//   Message  [127:0]  ciphertext, bit 127 is the MSB of byte 0
//   Key      [127:0]  cipher key, same byte order as Message
//   decipher [127:0]  plaintext result
//   done              high while decipher holds the result for the captured
//                     Message/Key pair
//
// Modports:
//   master : the side that supplies Message/Key and consumes the result
//   slave  : the decrypt core itself
// -----------------------------------------------------------------------------
interface decrypt128_if;
  logic [127:0] Message;
  logic [127:0] Key;
  logic [127:0] decipher;
  logic         done;

  modport master (
    output Message,
    output Key,
    input  decipher,
    input  done
  );

  modport slave (
    input  Message,
    input  Key,
    output decipher,
    output done
  );
endinterface

// File: rtl/decrypt128.sv
// -----------------------------------------------------------------------------
// decrypt128
// Iterative AES-128 inverse cipher (FIPS-197). Captures a ciphertext and key,
// expands the key on-chip at one round key per clock, then runs the initial
// AddRoundKey, nine inverse rounds and the inverse final round at one step per
// clock. The result appears 22 rising edges after capture.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   bus          decrypt128_if.slave: Message, Key in; decipher, done out
//   keySchedule  [128*(NR+1)-1:0] full round-key schedule, rk0 in the top
//                128 bits, rk10 in the bottom 128 bits (only present when
//                DECRYPT128_KEY_OUT_EN is defined)
//
// Parameters:
//   NK  key length in 32-bit words (only 4 is supported)
//   NR  number of rounds (only 10 is supported)
//
// Build option:
//   DECRYPT128_KEY_OUT_EN  exposes the internal key schedule as keySchedule.
// -----------------------------------------------------------------------------
module decrypt128 #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic               clk,
  input  logic               reset,
  decrypt128_if.slave        bus
`ifdef DECRYPT128_KEY_OUT_EN
  ,
  output logic [128*(NR+1)-1:0] keySchedule
`endif
);

  localparam int SCHED_W = 128 * (NR + 1);
  localparam int CNT_W   = $clog2(2 * NR + 3);

  // Step counter values. 0 captures, 1..NR expand keys, NR+1 applies the
  // initial AddRoundKey, NR+2..2NR run the inverse rounds, 2NR+1 is the last
  // round and 2NR+2 is the idle/hold state.
  localparam logic [CNT_W-1:0] CNT_CAPTURE = '0;
  localparam logic [CNT_W-1:0] CNT_KEY_END = CNT_W'(NR);
  localparam logic [CNT_W-1:0] CNT_INIT    = CNT_W'(NR + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(2 * NR + 1);
  localparam logic [CNT_W-1:0] CNT_IDLE    = CNT_W'(2 * NR + 2);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // ---------------------------------------------------------------------------
  // Byte-level helpers
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_FWD[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
    return SBOX_INV[2047 - 8 * int'(b) -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input int i);
    logic [7:0] r;
    case (i)
      1:       r = 8'h01;
      2:       r = 8'h02;
      3:       r = 8'h04;
      4:       r = 8'h08;
      5:       r = 8'h10;
      6:       r = 8'h20;
      7:       r = 8'h40;
      8:       r = 8'h80;
      9:       r = 8'h1b;
      10:      r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State transforms. State byte (row r, column c) lives at byte index 4c+r,
  // so each column is one contiguous 32-bit word with row 0 in its MSB.
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8 * (4 * c + row) -: 8] =
          s[127 - 8 * (4 * ((c - row + 4) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      r[127 - 8 * n -: 8] = inv_sub_byte(s[127 - 8 * n -: 8]);
    end
    return r;
  endfunction

  // Column times the circulant {0e,0b,0d,09}; the multiples are built from
  // x2/x4/x8 so only xtime and XOR are needed.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0]  a   [4];
    logic [7:0]  x2  [4];
    logic [7:0]  x4  [4];
    logic [7:0]  x8  [4];
    logic [7:0]  m9  [4];
    logic [7:0]  m11 [4];
    logic [7:0]  m13 [4];
    logic [7:0]  m14 [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31 - 8 * i -: 8];
      x2[i]  = xtime(a[i]);
      x4[i]  = xtime(x2[i]);
      x8[i]  = xtime(x4[i]);
      m9[i]  = x8[i] ^ a[i];
      m11[i] = x8[i] ^ x2[i] ^ a[i];
      m13[i] = x8[i] ^ x4[i] ^ a[i];
      m14[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[31 - 8 * i -: 8] = m14[i] ^ m11[(i + 1) % 4] ^ m13[(i + 2) % 4] ^ m9[(i + 3) % 4];
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127 - 32 * c -: 32] = inv_mix_column(s[127 - 32 * c -: 32]);
    end
    return r;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] rk);
    return s ^ rk;
  endfunction

  function automatic logic [127:0] decrypt_round(input logic [127:0] s, input logic [127:0] rk);
    return inv_mix_columns(add_round_key(inv_sub_bytes(inv_shift_rows(s)), rk));
  endfunction

  function automatic logic [127:0] decrypt_last_round(input logic [127:0] s, input logic [127:0] rk);
    return add_round_key(inv_sub_bytes(inv_shift_rows(s)), rk);
  endfunction

  // One step of the AES-128 schedule: derive round key i from round key i-1.
  function automatic logic [127:0] key_expand_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0]  w [NK];
    logic [31:0]  t;
    logic [127:0] r;
    for (int i = 0; i < NK; i++) begin
      w[i] = rk[127 - 32 * i -: 32];
    end
    t = w[NK - 1];
    t = {t[23:0], t[31:24]};
    t = {sub_byte(t[31:24]), sub_byte(t[23:16]), sub_byte(t[15:8]), sub_byte(t[7:0])}
        ^ {rc, 24'h000000};
    r = '0;
    for (int i = 0; i < NK; i++) begin
      w[i] = w[i] ^ t;
      t    = w[i];
      r[127 - 32 * i -: 32] = w[i];
    end
    return r;
  endfunction

  // Round key idx sits at the top for idx 0 and at the bottom for idx NR.
  function automatic logic [127:0] round_key(input logic [SCHED_W-1:0] sched, input int idx);
    return sched[128 * (NR - idx) +: 128];
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [127:0]       msg_q,      msg_d;
  logic [127:0]       key_q,      key_d;
  logic [SCHED_W-1:0] sched_q,    sched_d;
  logic [127:0]       state_q,    state_d;
  logic [127:0]       decipher_q, decipher_d;
  logic               done_q,     done_d;
  logic               mismatch;

  // Next-state logic. A change on Message or Key at any point after capture
  // restarts the operation from a fresh capture; decipher keeps its old value
  // so a caller never sees a half-computed result.
  always_comb begin
    cnt_d      = cnt_q;
    msg_d      = msg_q;
    key_d      = key_q;
    sched_d    = sched_q;
    state_d    = state_q;
    decipher_d = decipher_q;
    done_d     = done_q;
    mismatch   = (bus.Message != msg_q) || (bus.Key != key_q);

    if ((cnt_q == CNT_CAPTURE) || mismatch) begin
      msg_d                      = bus.Message;
      key_d                      = bus.Key;
      sched_d                    = '0;
      sched_d[SCHED_W-1 -: 128]  = bus.Key;
      state_d                    = '0;
      done_d                     = 1'b0;
      cnt_d                      = CNT_W'(1);
    end else if (cnt_q <= CNT_KEY_END) begin
      sched_d[128 * (NR - int'(cnt_q)) +: 128] =
        key_expand_step(round_key(sched_q, int'(cnt_q) - 1), rcon(int'(cnt_q)));
      cnt_d = cnt_q + CNT_W'(1);
    end else if (cnt_q == CNT_INIT) begin
      state_d = add_round_key(msg_q, round_key(sched_q, NR));
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (cnt_q < CNT_LAST) begin
      // Counter NR+2 uses rk(NR-1), counting down to rk1 at 2NR.
      state_d = decrypt_round(state_q, round_key(sched_q, 2 * NR + 1 - int'(cnt_q)));
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (cnt_q == CNT_LAST) begin
      decipher_d = decrypt_last_round(state_q, round_key(sched_q, 0));
      done_d     = 1'b1;
      cnt_d      = CNT_IDLE;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= CNT_CAPTURE;
      msg_q      <= '0;
      key_q      <= '0;
      sched_q    <= '0;
      state_q    <= '0;
      decipher_q <= '0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      msg_q      <= msg_d;
      key_q      <= key_d;
      sched_q    <= sched_d;
      state_q    <= state_d;
      decipher_q <= decipher_d;
      done_q     <= done_d;
    end
  end

  assign bus.decipher = decipher_q;
  assign bus.done     = done_q;

`ifdef DECRYPT128_KEY_OUT_EN
  assign keySchedule = sched_q;
`endif

endmodule

// File: tb/tb_decrypt128.sv
// -----------------------------------------------------------------------------
// tb_decrypt128
// Self-checking bench for decrypt128. Known-answer vectors come from a table;
// random ciphertext/key pairs are checked against an AES-128 inverse-cipher
// model that builds its S-boxes from GF(2^8) inversion and the affine map.
// -----------------------------------------------------------------------------
module tb_decrypt128;

  localparam int LATENCY = 22;

  logic clk;
  logic reset;

  decrypt128_if bus ();

`ifdef DECRYPT128_KEY_OUT_EN
  logic [1407:0] key_sched;
`endif

  decrypt128 dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus)
`ifdef DECRYPT128_KEY_OUT_EN
    ,
    .keySchedule (key_sched)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int           tests_run;
  int           fail_cnt;
  logic [127:0] last_result;

  typedef struct {
    logic [127:0] msg;
    logic [127:0] key;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [3];

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit   [7:0]  sb  [256];
  bit   [7:0]  isb [256];
  logic [31:0] m_w [44];

  function automatic bit [7:0] gmul(bit [7:0] a, bit [7:0] b);
    bit [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic void build_sboxes();
    for (int x = 0; x < 256; x++) begin
      bit [7:0] v;
      bit [7:0] inv;
      bit [7:0] s;
      v   = 8'(x);
      inv = 8'h01;
      if (v == 8'h00) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, v);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x]  = s;
      isb[s] = v;
    end
  endfunction

  function automatic void expand_key(logic [127:0] key);
    logic [31:0] t;
    bit   [7:0]  rc;
    for (int i = 0; i < 4; i++) m_w[i] = key[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = m_w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      m_w[i] = m_w[i - 4] ^ t;
    end
  endfunction

  function automatic bit [7:0] rk_byte(int i, int n);
    return m_w[4 * i + n / 4][31 - 8 * (n % 4) -: 8];
  endfunction

  function automatic logic [127:0] model_decrypt(logic [127:0] ct, logic [127:0] key);
    bit [7:0]     st [4][4];
    bit [7:0]     t  [4][4];
    logic [127:0] out;
    expand_key(key);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        st[r][c] = ct[127 - 8 * (4 * c + r) -: 8] ^ rk_byte(10, 4 * c + r);
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = isb[st[r][(c - r + 4) % 4]] ^ rk_byte(rnd, 4 * c + r);
      if (rnd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            st[r][c] = gmul(8'h0e, t[r][c]) ^ gmul(8'h0b, t[(r + 1) % 4][c])
                     ^ gmul(8'h0d, t[(r + 2) % 4][c]) ^ gmul(8'h09, t[(r + 3) % 4][c]);
      end else begin
        st = t;
      end
    end
    out = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        out[127 - 8 * (4 * c + r) -: 8] = st[r][c];
    return out;
  endfunction

  // ---------------------------------------------------------------------------
  // Bench tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [127:0] msg, input logic [127:0] key);
    bus.Message = msg;
    bus.Key     = key;
  endtask

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a pair and check the full 22-edge run: result withheld for 21 edges,
  // then presented with done on edge 22.
  task automatic run_vector(input logic [127:0] msg, input logic [127:0] key,
                            input logic [127:0] pt, input string tag);
    apply_stimulus(msg, key);
    for (int e = 1; e < LATENCY; e++) begin
      tick();
      check_output({tag, " busy done"}, {127'b0, bus.done}, 128'd0);
      check_output({tag, " busy decipher"}, bus.decipher, last_result);
    end
    tick();
    check_output({tag, " final done"}, {127'b0, bus.done}, 128'd1);
    check_output({tag, " final decipher"}, bus.decipher, pt);
`ifdef DECRYPT128_KEY_OUT_EN
    expand_key(key);
    for (int i = 0; i < 11; i++) begin
      check_output($sformatf("%s rk%0d", tag, i), key_sched[1407 - 128 * i -: 128],
                   {m_w[4 * i], m_w[4 * i + 1], m_w[4 * i + 2], m_w[4 * i + 3]});
    end
`endif
    last_result = pt;
  endtask

  task automatic hold_check(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check_output({tag, " hold done"}, {127'b0, bus.done}, 128'd1);
      check_output({tag, " hold decipher"}, bus.decipher, last_result);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [127:0] m;
    logic [127:0] k;
    logic [127:0] dm;
    logic [127:0] dk;
    int           ab;

    vecs[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0,
                128'h0};

    tests_run   = 0;
    fail_cnt    = 0;
    last_result = '0;
    clk         = 1'b0;
    reset       = 1'b0;
    apply_stimulus('0, '0);
    build_sboxes();

    // Reset state, including across clock edges while held.
    #1;
    check_output("reset done", {127'b0, bus.done}, 128'd0);
    check_output("reset decipher", bus.decipher, 128'd0);
    tick();
    tick();
    check_output("reset held done", {127'b0, bus.done}, 128'd0);
    check_output("reset held decipher", bus.decipher, 128'd0);
    reset = 1'b1;

    // Known-answer vectors, each held 50 cycles after completion.
    for (int i = 0; i < 3; i++) begin
      run_vector(vecs[i].msg, vecs[i].key, vecs[i].pt, $sformatf("kat%0d", i));
      hold_check(50, $sformatf("kat%0d", i));
    end

`ifdef DECRYPT128_KEY_OUT_EN
    run_vector(vecs[0].msg, vecs[0].key, vecs[0].pt, "kat0 again");
    check_output("kat0 rk10 const", key_sched[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
`endif

    // Reset asserted mid-operation clears outputs immediately.
    apply_stimulus(vecs[0].msg, vecs[0].key);
    for (int e = 0; e < 10; e++) tick();
    reset = 1'b0;
    #1;
    check_output("midreset done", {127'b0, bus.done}, 128'd0);
    check_output("midreset decipher", bus.decipher, 128'd0);
    for (int e = 0; e < 3; e++) tick();
    check_output("midreset held decipher", bus.decipher, 128'd0);
    reset       = 1'b1;
    last_result = '0;
    run_vector(vecs[0].msg, vecs[0].key, vecs[0].pt, "post reset");

    // Switch vectors at E15: vector 1 never appears.
    reset = 1'b0;
    tick();
    reset       = 1'b1;
    last_result = '0;
    apply_stimulus(vecs[0].msg, vecs[0].key);
    for (int e = 1; e < 15; e++) begin
      tick();
      check_output("switch pre done", {127'b0, bus.done}, 128'd0);
      check_output("switch pre decipher", bus.decipher, 128'd0);
    end
    run_vector(vecs[1].msg, vecs[1].key, vecs[1].pt, "switch");

    // Key-only change after completion restarts.
    run_vector(vecs[0].msg, vecs[0].key, vecs[0].pt, "keychg base");
    run_vector(vecs[0].msg, vecs[1].key, model_decrypt(vecs[0].msg, vecs[1].key), "keychg");

    // Random pairs against the model, some preceded by an aborted decoy.
    for (int i = 0; i < 16; i++) begin
      m = {$urandom(), $urandom(), $urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (i % 3 == 1) begin
        dm = {$urandom(), $urandom(), $urandom(), $urandom()};
        dk = {$urandom(), $urandom(), $urandom(), $urandom()};
        ab = int'($urandom_range(1, 21));
        apply_stimulus(dm, dk);
        for (int e = 0; e < ab; e++) begin
          tick();
          check_output("decoy done", {127'b0, bus.done}, 128'd0);
          check_output("decoy decipher", bus.decipher, last_result);
        end
      end
      run_vector(m, k, model_decrypt(m, k), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
